// File: rtl/axi4_burst_writer.sv
// Write-side DMA master: one command (address, beat count) becomes a series of
// AXI4 INCR bursts, never crossing a 4 KB page, with one burst outstanding at a time.
module axi4_burst_writer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BURST  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [CNT_WIDTH-1:0]    cmd_beats,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic [0:0]              M_AXI_AWID,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]              M_AXI_AWLEN,
  output logic [2:0]              M_AXI_AWSIZE,
  output logic [1:0]              M_AXI_AWBURST,
  output logic                    M_AXI_AWLOCK,
  output logic [3:0]              M_AXI_AWCACHE,
  output logic [2:0]              M_AXI_AWPROT,
  output logic [3:0]              M_AXI_AWQOS,
  output logic [7:0]              M_AXI_AWUSER,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WUSER,
  output logic                    M_AXI_WLAST,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [0:0]              M_AXI_BID,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic [7:0]              M_AXI_BUSER,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY
);

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_AW, S_W, S_B, S_FIN} state_t;

  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr, r_awaddr;
  logic [CNT_WIDTH-1:0]  r_rem;
  logic [8:0]            r_len, r_cnt;
  logic [7:0]            r_awlen;
  logic                  r_awvalid, r_err, r_done;

  logic [12:0]           w_page_bytes;
  logic [9:0]            w_page_beats;
  logic [8:0]            w_cap, w_len;
  logic                  w_wbeat;
  logic                  w_unused;

  // Burst length = min(remaining, MAX_BURST, beats left before the next 4 KB page)
  assign w_page_bytes = 13'h1000 - {1'b0, r_addr[11:0]};
  assign w_page_beats = w_page_bytes[12:3];
  assign w_cap        = (w_page_beats > 10'(MAX_BURST)) ? 9'(MAX_BURST) : w_page_beats[8:0];
  assign w_len        = (CNT_WIDTH'(w_cap) > r_rem) ? 9'(r_rem) : w_cap;
  assign w_wbeat      = (r_state == S_W) && s_valid && M_AXI_WREADY;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (cmd_valid) w_next = (cmd_beats == '0) ? S_FIN : S_CALC;
      S_CALC: w_next = S_AW;
      S_AW:   if (M_AXI_AWREADY) w_next = S_W;
      S_W:    if (w_wbeat && (r_cnt == 9'd1)) w_next = S_B;
      S_B:    if (M_AXI_BVALID) w_next = (r_rem == CNT_WIDTH'(r_len)) ? S_FIN : S_CALC;
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_addr    <= '0;
      r_rem     <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_awaddr  <= '0;
      r_awlen   <= '0;
      r_awvalid <= 1'b0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIN);
      case (r_state)
        S_IDLE: if (cmd_valid) begin
          r_addr <= {cmd_addr[ADDR_WIDTH-1:3], 3'b000};
          r_rem  <= cmd_beats;
          r_err  <= 1'b0;
        end
        S_CALC: begin
          r_len     <= w_len;
          r_awaddr  <= r_addr;
          r_awlen   <= 8'(w_len - 9'd1);
          r_awvalid <= 1'b1;
        end
        S_AW: if (M_AXI_AWREADY) begin
          r_awvalid <= 1'b0;
          r_cnt     <= r_len;
        end
        S_W: if (w_wbeat) r_cnt <= r_cnt - 9'd1;
        // Error responses are recorded but never abort the remaining bursts
        S_B: if (M_AXI_BVALID) begin
          r_err  <= r_err | (M_AXI_BRESP != 2'b00);
          r_addr <= r_addr + ADDR_WIDTH'({r_len, 3'b000});
          r_rem  <= r_rem - CNT_WIDTH'(r_len);
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready     = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign err           = r_err;
  assign s_ready       = (r_state == S_W) && M_AXI_WREADY;
  assign M_AXI_WVALID  = (r_state == S_W) && s_valid;
  assign M_AXI_WLAST   = (r_state == S_W) && (r_cnt == 9'd1);
  assign M_AXI_WDATA   = s_data;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WUSER   = '0;
  assign M_AXI_BREADY  = (r_state == S_B);
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWLEN   = r_awlen;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_AWID    = 1'b0;
  assign M_AXI_AWSIZE  = 3'b011;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWQOS   = 4'b0000;
  assign M_AXI_AWUSER  = 8'h00;

  assign w_unused = ^{cmd_addr[2:0], M_AXI_BID, M_AXI_BUSER};

endmodule

// File: tb/tb_axi4_burst_writer.sv
// Directed bench for axi4_burst_writer: a reactive AXI slave / upstream source
// runs alongside a linear sequence of commands with hand-computed expectations.
module tb_axi4_burst_writer;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_addr = '0;
  logic [15:0] cmd_beats = '0;
  logic [63:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready, busy, done, err;
  logic [0:0]  M_AXI_AWID;
  logic [31:0] M_AXI_AWADDR;
  logic [7:0]  M_AXI_AWLEN;
  logic [2:0]  M_AXI_AWSIZE;
  logic [1:0]  M_AXI_AWBURST;
  logic        M_AXI_AWLOCK;
  logic [3:0]  M_AXI_AWCACHE;
  logic [2:0]  M_AXI_AWPROT;
  logic [3:0]  M_AXI_AWQOS;
  logic [7:0]  M_AXI_AWUSER;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY = 1'b0;
  logic [63:0] M_AXI_WDATA;
  logic [7:0]  M_AXI_WSTRB, M_AXI_WUSER;
  logic        M_AXI_WLAST, M_AXI_WVALID;
  logic        M_AXI_WREADY = 1'b0;
  logic [0:0]  M_AXI_BID = 1'b0;
  logic [1:0]  M_AXI_BRESP = 2'b00;
  logic [7:0]  M_AXI_BUSER = 8'h00;
  logic        M_AXI_BVALID = 1'b0;
  logic        M_AXI_BREADY;

  always #5 ACLK = ~ACLK;

  axi4_burst_writer dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .busy(busy), .done(done), .err(err),
    .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
    .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
    .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS),
    .M_AXI_AWUSER(M_AXI_AWUSER), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WUSER(M_AXI_WUSER),
    .M_AXI_WLAST(M_AXI_WLAST), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BUSER(M_AXI_BUSER),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY)
  );

  int          vec_cnt = 0;
  int          mis_cnt = 0;
  bit          rnd = 1'b0;
  int          err_burst = -1;
  int          src_left = 0, src_idx = 0;
  bit          s_hold = 1'b0, b_hold = 1'b0;
  int          b_pend = 0, b_idx = 0;
  int          aw_cnt = 0, w_cnt = 0, wlast_cnt = 0, done_cnt = 0, cur_left = 0;
  bit          aw_seen = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [7:0]  prev_len = '0;
  logic [15:0] cmd_tag = '0;
  logic [31:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];
  int          wlast_pos_q[$];
  int          burst_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      mis_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [15:0] tag, input int i);
    logic [31:0] iv;
    iv = i;
    return {16'hC0DE, tag, iv};
  endfunction

  // Slave + upstream source; inputs change on the falling edge, handshakes
  // are evaluated 1 ns before the rising edge.
  initial begin
    forever begin
      @(negedge ACLK);
      M_AXI_AWREADY = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
      M_AXI_WREADY  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (!s_hold) begin
        if (src_left > 0) begin
          s_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
          s_data  = pat(cmd_tag, src_idx);
        end else s_valid = 1'b0;
      end
      if (!b_hold) begin
        if (b_pend > 0) begin
          M_AXI_BVALID = rnd ? ($urandom_range(0, 1) == 0) : 1'b1;
          M_AXI_BRESP  = (b_idx == err_burst) ? 2'b10 : 2'b00;
        end else M_AXI_BVALID = 1'b0;
      end
      #4;
      if (M_AXI_AWVALID) aw_seen = 1'b1;
      if (ARESETN) begin
        if (prev_stall)
          check("aw_hold", {M_AXI_AWVALID, M_AXI_AWLEN, M_AXI_AWADDR}, {1'b1, prev_len, prev_addr});
        prev_stall = M_AXI_AWVALID && !M_AXI_AWREADY;
        prev_addr  = M_AXI_AWADDR;
        prev_len   = M_AXI_AWLEN;
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin
          aw_cnt++;
          aw_addr_q.push_back(M_AXI_AWADDR);
          aw_len_q.push_back(M_AXI_AWLEN);
          burst_q.push_back(int'(M_AXI_AWLEN) + 1);
        end
        if (M_AXI_WVALID && M_AXI_WREADY) begin
          if (cur_left == 0 && burst_q.size() > 0) cur_left = burst_q.pop_front();
          check("wdata", M_AXI_WDATA, pat(cmd_tag, w_cnt));
          check("wlast", M_AXI_WLAST, cur_left == 1);
          w_cnt++;
          cur_left--;
          if (M_AXI_WLAST) begin
            wlast_cnt++;
            wlast_pos_q.push_back(w_cnt);
            b_pend++;
          end
        end
        if (s_valid && s_ready) begin
          src_idx++;
          src_left--;
        end
        s_hold = s_valid && !s_ready;
        if (M_AXI_BVALID && M_AXI_BREADY) begin
          b_pend--;
          b_idx++;
        end
        b_hold = M_AXI_BVALID && !M_AXI_BREADY;
        if (done) done_cnt++;
      end else prev_stall = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d vectors, %0d miscompares", vec_cnt, mis_cnt);
    $fatal(1, "watchdog");
  end

  task automatic clear_log();
    aw_cnt = 0; w_cnt = 0; wlast_cnt = 0; done_cnt = 0; cur_left = 0; b_idx = 0;
    aw_seen = 1'b0;
    aw_addr_q.delete(); aw_len_q.delete(); wlast_pos_q.delete(); burst_q.delete();
    cmd_tag++;
  endtask

  task automatic issue(input logic [31:0] a, input logic [15:0] n);
    @(negedge ACLK);
    clear_log();
    check("cmd_ready", cmd_ready, 1'b1);
    cmd_addr  = a;
    cmd_beats = n;
    cmd_valid = 1'b1;
    src_left  = int'(n);
    src_idx   = 0;
    @(negedge ACLK);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge ACLK);
      #1;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", got, 1'b1);
  endtask

  task automatic expect_burst(input int i, input logic [31:0] a, input logic [7:0] l);
    check($sformatf("awaddr%0d", i), (aw_addr_q.size() > i) ? aw_addr_q[i] : 32'hDEAD_BEEF, a);
    check($sformatf("awlen%0d", i), (aw_len_q.size() > i) ? aw_len_q[i] : 8'hEE, l);
  endtask

  task automatic check_idle_outputs(input string pfx);
    check({pfx, "_awvalid"}, M_AXI_AWVALID, 1'b0);
    check({pfx, "_wvalid"},  M_AXI_WVALID, 1'b0);
    check({pfx, "_bready"},  M_AXI_BREADY, 1'b0);
    check({pfx, "_s_ready"}, s_ready, 1'b0);
    check({pfx, "_busy"},    busy, 1'b0);
    check({pfx, "_done"},    done, 1'b0);
    check({pfx, "_err"},     err, 1'b0);
    check({pfx, "_awaddr"},  M_AXI_AWADDR, 32'h0);
    check({pfx, "_awlen"},   M_AXI_AWLEN, 8'h0);
    check({pfx, "_cmd_rdy"}, cmd_ready, 1'b1);
  endtask

  initial begin
    bit reached;
    repeat (3) @(negedge ACLK);
    #2 ARESETN = 1'b1;
    @(negedge ACLK);
    #1 check_idle_outputs("rst");

    // Three bursts within one page
    issue(32'h0000_1000, 16'd40);
    wait_done(500);
    check("t1_err", err, 1'b0);
    repeat (3) @(negedge ACLK);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_aw_cnt", aw_cnt, 3);
    expect_burst(0, 32'h0000_1000, 8'd15);
    expect_burst(1, 32'h0000_1080, 8'd15);
    expect_burst(2, 32'h0000_1100, 8'd7);
    check("t1_w_cnt", w_cnt, 40);
    check("t1_wlast_cnt", wlast_cnt, 3);
    check("t1_wlast_pos0", (wlast_pos_q.size() > 0) ? wlast_pos_q[0] : -1, 16);
    check("t1_wlast_pos1", (wlast_pos_q.size() > 1) ? wlast_pos_q[1] : -1, 32);
    check("t1_wlast_pos2", (wlast_pos_q.size() > 2) ? wlast_pos_q[2] : -1, 40);

    // 4 KB page split: 4 beats to 0x2000, then 6
    issue(32'h0000_1FE0, 16'd10);
    wait_done(500);
    repeat (3) @(negedge ACLK);
    check("t2_aw_cnt", aw_cnt, 2);
    expect_burst(0, 32'h0000_1FE0, 8'd3);
    expect_burst(1, 32'h0000_2000, 8'd5);
    check("t2_w_cnt", w_cnt, 10);

    // Zero-beat command: FIN only, done two cycles after accept
    issue(32'h0000_9000, 16'd0);
    #1;
    check("t3_busy_c1", busy, 1'b1);
    check("t3_done_c1", done, 1'b0);
    @(negedge ACLK);
    #1;
    check("t3_busy_c2", busy, 1'b0);
    check("t3_done_c2", done, 1'b1);
    @(negedge ACLK);
    #1;
    check("t3_done_c3", done, 1'b0);
    check("t3_aw_seen", aw_seen, 1'b0);
    check("t3_done_cnt", done_cnt, 1);

    // Random handshakes and upstream gaps
    rnd = 1'b1;
    issue(32'h0000_4000, 16'd33);
    wait_done(3000);
    rnd = 1'b0;
    repeat (3) @(negedge ACLK);
    check("t4_aw_cnt", aw_cnt, 3);
    expect_burst(0, 32'h0000_4000, 8'd15);
    expect_burst(1, 32'h0000_4080, 8'd15);
    expect_burst(2, 32'h0000_4100, 8'd0);
    check("t4_w_cnt", w_cnt, 33);
    check("t4_wlast_cnt", wlast_cnt, 3);
    check("t4_done_cnt", done_cnt, 1);

    // SLVERR on the second burst: no abort, err sticky until next accept
    err_burst = 1;
    issue(32'h0000_5000, 16'd32);
    wait_done(500);
    check("t5_err_done", err, 1'b1);
    repeat (2) @(negedge ACLK);
    check("t5_aw_cnt", aw_cnt, 2);
    check("t5_w_cnt", w_cnt, 32);
    check("t5_err_held", err, 1'b1);
    err_burst = -1;
    issue(32'h0000_6000, 16'd8);
    #1;
    check("t5_err_clr", err, 1'b0);
    check("t5_busy", busy, 1'b1);
    wait_done(500);
    check("t5_err_after", err, 1'b0);
    expect_burst(0, 32'h0000_6000, 8'd7);

    // Asynchronous reset during W beat 5 of 16
    issue(32'h0000_7000, 16'd16);
    reached = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge ACLK);
      if (w_cnt == 4) begin
        reached = 1'b1;
        break;
      end
    end
    check("t6_reach_beat5", reached, 1'b1);
    #1 check("t6_wvalid_pre", M_AXI_WVALID, 1'b1);
    #1 ARESETN = 1'b0;
    #1 check_idle_outputs("t6");
    src_left = 0; s_valid = 1'b0; s_hold = 1'b0; b_hold = 1'b0; b_pend = 0;
    M_AXI_BVALID = 1'b0;
    burst_q.delete();
    cur_left = 0;
    repeat (2) @(negedge ACLK);
    #2 ARESETN = 1'b1;
    @(negedge ACLK);
    #1 check("t6_cmd_ready", cmd_ready, 1'b1);
    issue(32'h0000_8000, 16'd20);
    wait_done(500);
    repeat (3) @(negedge ACLK);
    check("t6_aw_cnt", aw_cnt, 2);
    expect_burst(0, 32'h0000_8000, 8'd15);
    expect_burst(1, 32'h0000_8080, 8'd3);
    check("t6_w_cnt", w_cnt, 20);
    check("t6_err", err, 1'b0);
    check("t6_done_cnt", done_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
